// File: rtl/axonerve_kvs_kernel.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axonerve_kvs_kernel
//
// Key/value store with ternary (masked) search. Commands are pushed into a
// FIFO. When the table is ready they are popped one per cycle into an
// execute stage. The execute stage compares the command against every entry
// in parallel and registers the result one cycle later. For an idle FIFO the
// result therefore appears two rising edges after the push is sampled.
//
// Ports
//   I_CLK, I_RST                  clock, synchronous active-high reset
//   I_CMD_INIT                    table-clear request (flushes FIFO)
//   I_CMD_VALID                   command push strobe
//   I_CMD_{ERASE,WRITE,READ,SEARCH,UPDATE}  one-hot opcode bits
//   I_KEY_DAT/I_EKEY_MSK          key and don't-care mask (1 = don't care)
//   I_KEY_PRI/I_KEY_VALUE         priority (0 highest) and value
//   O_VERSION                     constant version word
//   O_READY/O_WAIT                table ready / host should hold off
//   O_ACK/O_ENT_ERR               completion pulse and error flag
//   O_SINGLE_HIT/O_MULTIL_HIT     hit classification
//   O_KEY_DAT..O_KEY_VALUE        affected or winning entry (0 on miss/error)
//   O_CMD_EMPTY/O_CMD_FULL        FIFO status
//   O_ENT_FULL                    every entry valid
// ---------------------------------------------------------------------------
module axonerve_kvs_kernel #(
    parameter int ENTRIES    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         I_CLK,
    input  logic         I_RST,
    input  logic         I_CMD_INIT,
    input  logic         I_CMD_VALID,
    input  logic         I_CMD_ERASE,
    input  logic         I_CMD_WRITE,
    input  logic         I_CMD_READ,
    input  logic         I_CMD_SEARCH,
    input  logic         I_CMD_UPDATE,
    input  logic [127:0] I_KEY_DAT,
    input  logic [127:0] I_EKEY_MSK,
    input  logic [6:0]   I_KEY_PRI,
    input  logic [31:0]  I_KEY_VALUE,
    output logic [31:0]  O_VERSION,
    output logic         O_READY,
    output logic         O_WAIT,
    output logic         O_ACK,
    output logic         O_ENT_ERR,
    output logic         O_SINGLE_HIT,
    output logic         O_MULTIL_HIT,
    output logic [127:0] O_KEY_DAT,
    output logic [127:0] O_EKEY_MSK,
    output logic [6:0]   O_KEY_PRI,
    output logic [31:0]  O_KEY_VALUE,
    output logic         O_CMD_EMPTY,
    output logic         O_CMD_FULL,
    output logic         O_ENT_FULL
);

    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = 5 + 128 + 128 + 7 + 32;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [CW-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr_q;
    logic [FW-1:0] rd_ptr_q;
    logic [FW:0]   count_q;
    logic [FW:0]   count_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [CW-1:0] push_word;
    logic [CW-1:0] head_word;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] init_cnt_q;
    logic [IW-1:0] init_cnt_d;
    logic          init_clr;

    function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
        return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
    endfunction

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (FW+1)'(FIFO_DEPTH));
    // INIT wins over a same-cycle push; pushes are still accepted while
    // the table is initialising, only popping waits for ready.
    assign push       = I_CMD_VALID && !I_CMD_INIT && !fifo_full;
    assign pop        = (state_q == ST_RUN) && !fifo_empty && !I_CMD_INIT;
    assign push_word  = {I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ, I_CMD_SEARCH,
                         I_CMD_UPDATE, I_KEY_DAT, I_EKEY_MSK, I_KEY_PRI,
                         I_KEY_VALUE};
    assign head_word  = fifo_mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FW+1)'(1);
            2'b01:   count_d = count_q - (FW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST || I_CMD_INIT) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Init / run state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        init_clr   = 1'b0;
        if (I_CMD_INIT) begin
            state_d    = ST_INIT;
            init_cnt_d = '0;
        end else if (state_q == ST_INIT) begin
            init_clr = 1'b1;
            if (init_cnt_q == IW'(ENTRIES - 1)) begin
                state_d = ST_RUN;
            end else begin
                init_cnt_d = init_cnt_q + IW'(1);
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Execute stage registers (command popped last cycle)
    // ------------------------------------------------------------------
    logic         s_vld_q;
    logic [4:0]   s_op_q;
    logic [127:0] s_key_q;
    logic [127:0] s_msk_q;
    logic [6:0]   s_pri_q;
    logic [31:0]  s_val_q;

    always_ff @(posedge I_CLK) begin
        if (I_RST || I_CMD_INIT) begin
            s_vld_q <= 1'b0;
        end else begin
            s_vld_q <= pop;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (pop) begin
            {s_op_q, s_key_q, s_msk_q, s_pri_q, s_val_q} <= head_word;
        end
    end

    // ------------------------------------------------------------------
    // Entry table and parallel match
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q;
    logic [127:0]       tbl_key_q [ENTRIES];
    logic [127:0]       tbl_msk_q [ENTRIES];
    logic [6:0]         tbl_pri_q [ENTRIES];
    logic [31:0]        tbl_val_q [ENTRIES];

    logic [ENTRIES-1:0] exact_vec;
    logic [ENTRIES-1:0] srch_vec;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
        assign exact_vec[gi] = valid_q[gi] && (tbl_key_q[gi] == s_key_q) &&
                               (tbl_msk_q[gi] == s_msk_q);
        assign srch_vec[gi]  = valid_q[gi] &&
                               (((tbl_key_q[gi] ^ s_key_q) &
                                 ~(tbl_msk_q[gi] | s_msk_q)) == '0);
    end

    logic          exact_hit;
    logic [IW-1:0] exact_idx;
    logic          free_any;
    logic [IW-1:0] free_idx;
    logic          hit_any;
    logic          hit_multi;
    logic [IW-1:0] win_idx;
    logic [6:0]    win_pri;

    // Lowest-index exact match / free slot; search winner is the lowest
    // priority value, strict '<' keeps the lower index on ties.
    always_comb begin
        exact_hit = 1'b0;
        exact_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        hit_any   = 1'b0;
        hit_multi = 1'b0;
        win_idx   = '0;
        win_pri   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (exact_vec[i] && !exact_hit) begin
                exact_hit = 1'b1;
                exact_idx = IW'(i);
            end
            if (!valid_q[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (srch_vec[i]) begin
                if (!hit_any) begin
                    hit_any = 1'b1;
                    win_idx = IW'(i);
                    win_pri = tbl_pri_q[i];
                end else begin
                    hit_multi = 1'b1;
                    if (tbl_pri_q[i] < win_pri) begin
                        win_idx = IW'(i);
                        win_pri = tbl_pri_q[i];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command execution
    // ------------------------------------------------------------------
    logic         op_erase;
    logic         op_write;
    logic         op_read;
    logic         op_search;
    logic         op_update;
    logic         op_legal;
    logic         exec_en;

    assign {op_erase, op_write, op_read, op_search, op_update} = s_op_q;
    assign op_legal = (s_op_q != '0) && ((s_op_q & (s_op_q - 5'd1)) == '0);
    // A same-cycle INIT abandons the command in the execute stage.
    assign exec_en  = s_vld_q && !I_CMD_INIT;

    logic          ack_d;
    logic          err_d;
    logic          single_d;
    logic          multi_d;
    logic [127:0]  rkey_d;
    logic [127:0]  rmsk_d;
    logic [6:0]    rpri_d;
    logic [31:0]   rval_d;
    logic          tbl_wr;
    logic          tbl_upd;
    logic          tbl_ers;
    logic [IW-1:0] tbl_idx;

    always_comb begin
        ack_d    = exec_en;
        err_d    = 1'b0;
        single_d = 1'b0;
        multi_d  = 1'b0;
        rkey_d   = '0;
        rmsk_d   = '0;
        rpri_d   = '0;
        rval_d   = '0;
        tbl_wr   = 1'b0;
        tbl_upd  = 1'b0;
        tbl_ers  = 1'b0;
        tbl_idx  = exact_idx;
        if (exec_en) begin
            if (!op_legal) begin
                err_d = 1'b1;
            end else if (op_write) begin
                if (exact_hit || !free_any) begin
                    err_d = 1'b1;
                end else begin
                    tbl_wr  = 1'b1;
                    tbl_idx = free_idx;
                    rkey_d  = s_key_q;
                    rmsk_d  = s_msk_q;
                    rpri_d  = s_pri_q;
                    rval_d  = s_val_q;
                end
            end else if (op_search) begin
                if (hit_any) begin
                    single_d = !hit_multi;
                    multi_d  = hit_multi;
                    rkey_d   = tbl_key_q[win_idx];
                    rmsk_d   = tbl_msk_q[win_idx];
                    rpri_d   = tbl_pri_q[win_idx];
                    rval_d   = tbl_val_q[win_idx];
                end
            end else if (!exact_hit) begin
                err_d = 1'b1;
            end else begin
                // READ, UPDATE and ERASE on an exact hit
                single_d = 1'b1;
                tbl_upd  = op_update;
                tbl_ers  = op_erase;
                rkey_d   = tbl_key_q[exact_idx];
                rmsk_d   = tbl_msk_q[exact_idx];
                rpri_d   = op_update ? s_pri_q : tbl_pri_q[exact_idx];
                rval_d   = op_update ? s_val_q : tbl_val_q[exact_idx];
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            valid_q <= '0;
        end else begin
            if (init_clr) valid_q[init_cnt_q] <= 1'b0;
            if (tbl_wr)   valid_q[tbl_idx]    <= 1'b1;
            if (tbl_ers)  valid_q[tbl_idx]    <= 1'b0;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (tbl_wr) begin
            tbl_key_q[tbl_idx] <= s_key_q;
            tbl_msk_q[tbl_idx] <= s_msk_q;
        end
        if (tbl_wr || tbl_upd) begin
            tbl_pri_q[tbl_idx] <= s_pri_q;
            tbl_val_q[tbl_idx] <= s_val_q;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    logic         ack_q;
    logic         err_q;
    logic         single_q;
    logic         multi_q;
    logic [127:0] rkey_q;
    logic [127:0] rmsk_q;
    logic [6:0]   rpri_q;
    logic [31:0]  rval_q;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            single_q <= 1'b0;
            multi_q  <= 1'b0;
            rkey_q   <= '0;
            rmsk_q   <= '0;
            rpri_q   <= '0;
            rval_q   <= '0;
        end else begin
            ack_q    <= ack_d;
            err_q    <= err_d;
            single_q <= single_d;
            multi_q  <= multi_d;
            rkey_q   <= rkey_d;
            rmsk_q   <= rmsk_d;
            rpri_q   <= rpri_d;
            rval_q   <= rval_d;
        end
    end

    assign O_VERSION    = 32'h0001_0000;
    assign O_READY      = (state_q == ST_RUN);
    assign O_WAIT       = (state_q != ST_RUN) || fifo_full;
    assign O_ACK        = ack_q;
    assign O_ENT_ERR    = err_q;
    assign O_SINGLE_HIT = single_q;
    assign O_MULTIL_HIT = multi_q;
    assign O_KEY_DAT    = rkey_q;
    assign O_EKEY_MSK   = rmsk_q;
    assign O_KEY_PRI    = rpri_q;
    assign O_KEY_VALUE  = rval_q;
    assign O_CMD_EMPTY  = fifo_empty;
    assign O_CMD_FULL   = fifo_full;
    assign O_ENT_FULL   = &valid_q;

endmodule

// File: tb/tb_axonerve_kvs_kernel.sv
`timescale 1ns/1ps
// Directed testbench for axonerve_kvs_kernel.
module tb_axonerve_kvs_kernel;

    localparam logic [4:0] OP_ERASE  = 5'b10000;
    localparam logic [4:0] OP_WRITE  = 5'b01000;
    localparam logic [4:0] OP_READ   = 5'b00100;
    localparam logic [4:0] OP_SEARCH = 5'b00010;
    localparam logic [4:0] OP_UPDATE = 5'b00001;

    localparam logic [127:0] K_CAFE = {4{32'habadcafe}};
    localparam logic [127:0] K_BEEF = {4{32'hdeadbeef}};

    logic         I_CLK = 1'b0;
    logic         I_RST = 1'b1;
    logic         I_CMD_INIT = 1'b0;
    logic         I_CMD_VALID = 1'b0;
    logic         I_CMD_ERASE = 1'b0;
    logic         I_CMD_WRITE = 1'b0;
    logic         I_CMD_READ = 1'b0;
    logic         I_CMD_SEARCH = 1'b0;
    logic         I_CMD_UPDATE = 1'b0;
    logic [127:0] I_KEY_DAT = '0;
    logic [127:0] I_EKEY_MSK = '0;
    logic [6:0]   I_KEY_PRI = '0;
    logic [31:0]  I_KEY_VALUE = '0;
    logic [31:0]  O_VERSION;
    logic         O_READY;
    logic         O_WAIT;
    logic         O_ACK;
    logic         O_ENT_ERR;
    logic         O_SINGLE_HIT;
    logic         O_MULTIL_HIT;
    logic [127:0] O_KEY_DAT;
    logic [127:0] O_EKEY_MSK;
    logic [6:0]   O_KEY_PRI;
    logic [31:0]  O_KEY_VALUE;
    logic         O_CMD_EMPTY;
    logic         O_CMD_FULL;
    logic         O_ENT_FULL;

    int checks = 0;
    int failures = 0;

    // Captured result of the last do_cmd
    logic         r_ack;
    int           r_lat;
    logic         r_err;
    logic         r_single;
    logic         r_multi;
    logic [127:0] r_key;
    logic [6:0]   r_pri;
    logic [31:0]  r_val;

    always #5 I_CLK = ~I_CLK;

    axonerve_kvs_kernel #(.ENTRIES(16), .FIFO_DEPTH(8)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_CMD_INIT(I_CMD_INIT),
        .I_CMD_VALID(I_CMD_VALID), .I_CMD_ERASE(I_CMD_ERASE),
        .I_CMD_WRITE(I_CMD_WRITE), .I_CMD_READ(I_CMD_READ),
        .I_CMD_SEARCH(I_CMD_SEARCH), .I_CMD_UPDATE(I_CMD_UPDATE),
        .I_KEY_DAT(I_KEY_DAT), .I_EKEY_MSK(I_EKEY_MSK),
        .I_KEY_PRI(I_KEY_PRI), .I_KEY_VALUE(I_KEY_VALUE),
        .O_VERSION(O_VERSION), .O_READY(O_READY), .O_WAIT(O_WAIT),
        .O_ACK(O_ACK), .O_ENT_ERR(O_ENT_ERR), .O_SINGLE_HIT(O_SINGLE_HIT),
        .O_MULTIL_HIT(O_MULTIL_HIT), .O_KEY_DAT(O_KEY_DAT),
        .O_EKEY_MSK(O_EKEY_MSK), .O_KEY_PRI(O_KEY_PRI),
        .O_KEY_VALUE(O_KEY_VALUE), .O_CMD_EMPTY(O_CMD_EMPTY),
        .O_CMD_FULL(O_CMD_FULL), .O_ENT_FULL(O_ENT_FULL)
    );

    // Push one command (called 1 time unit after a rising edge) and wait a
    // bounded number of cycles for its ACK; r_lat counts edges after the
    // sampling edge.
    task automatic do_cmd(input logic [4:0] op, input logic [127:0] key,
                          input logic [127:0] msk, input logic [6:0] pri,
                          input logic [31:0] val);
        {I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ, I_CMD_SEARCH, I_CMD_UPDATE} = op;
        I_KEY_DAT   = key;
        I_EKEY_MSK  = msk;
        I_KEY_PRI   = pri;
        I_KEY_VALUE = val;
        I_CMD_VALID = 1'b1;
        @(posedge I_CLK); #1;
        I_CMD_VALID = 1'b0;
        {I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ, I_CMD_SEARCH, I_CMD_UPDATE} = 5'b0;
        r_ack = 1'b0; r_lat = 0; r_err = 1'b0; r_single = 1'b0; r_multi = 1'b0;
        r_key = '0; r_pri = '0; r_val = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge I_CLK); #1;
            if (O_ACK === 1'b1) begin
                r_ack = 1'b1; r_lat = c; r_err = O_ENT_ERR;
                r_single = O_SINGLE_HIT; r_multi = O_MULTIL_HIT;
                r_key = O_KEY_DAT; r_pri = O_KEY_PRI; r_val = O_KEY_VALUE;
                break;
            end
        end
        $display("txn op=%b key=%h ack=%0b lat=%0d err=%0b sh=%0b mh=%0b pri=%0d val=%h",
                 op, key, r_ack, r_lat, r_err, r_single, r_multi, r_pri, r_val);
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 40; c++) begin
            if (O_READY === 1'b1) break;
            @(posedge I_CLK); #1;
        end
    endtask

    task automatic pulse_init();
        I_CMD_INIT = 1'b1;
        @(posedge I_CLK); #1;
        I_CMD_INIT = 1'b0;
    endtask

    task automatic test_reset();
        I_RST = 1'b1;
        repeat (3) @(posedge I_CLK);
        #1;
        checks++; if (O_READY !== 1'b0 || O_ACK !== 1'b0 || O_CMD_EMPTY !== 1'b1 ||
                      O_WAIT !== 1'b1 || O_CMD_FULL !== 1'b0 || O_ENT_FULL !== 1'b0) begin
            failures++; $display("FAIL reset_flags: rdy=%b ack=%b empty=%b wait=%b full=%b efull=%b required 0 0 1 1 0 0",
                                 O_READY, O_ACK, O_CMD_EMPTY, O_WAIT, O_CMD_FULL, O_ENT_FULL);
        end
        checks++; if (O_VERSION !== 32'h0001_0000 || O_KEY_VALUE !== 32'h0 || O_KEY_DAT !== 128'h0) begin
            failures++; $display("FAIL reset_data: version=%h val=%h required 00010000 00000000", O_VERSION, O_KEY_VALUE);
        end
        I_RST = 1'b0;
        repeat (15) @(posedge I_CLK);
        #1;
        checks++; if (O_READY !== 1'b0) begin
            failures++; $display("FAIL ready_early: got %b required 0 after 15 cycles", O_READY);
        end
        @(posedge I_CLK); #1;
        checks++; if (O_READY !== 1'b1 || O_WAIT !== 1'b0) begin
            failures++; $display("FAIL ready_16: ready=%b wait=%b required 1 0", O_READY, O_WAIT);
        end
    endtask

    task automatic test_write_search();
        do_cmd(OP_WRITE, K_CAFE, '0, 7'd3, 32'h34343434);
        checks++; if (r_ack !== 1'b1 || r_lat != 2) begin
            failures++; $display("FAIL write_latency: ack=%b lat=%0d required 1 2", r_ack, r_lat);
        end
        checks++; if (r_err !== 1'b0 || r_val !== 32'h34343434 || r_key !== K_CAFE) begin
            failures++; $display("FAIL write_echo: err=%b val=%h required 0 34343434", r_err, r_val);
        end
        do_cmd(OP_SEARCH, K_CAFE, '0, 7'd0, 32'h0);
        checks++; if (r_ack !== 1'b1 || r_single !== 1'b1 || r_multi !== 1'b0 ||
                      r_err !== 1'b0 || r_val !== 32'h34343434 || r_pri !== 7'd3) begin
            failures++; $display("FAIL search_cafe: sh=%b mh=%b err=%b pri=%0d val=%h required 1 0 0 3 34343434",
                                 r_single, r_multi, r_err, r_pri, r_val);
        end
    endtask

    task automatic test_update();
        do_cmd(OP_WRITE, K_BEEF, '0, 7'd4, 32'ha5a5a5a5);
        checks++; if (r_ack !== 1'b1 || r_err !== 1'b0) begin
            failures++; $display("FAIL write_beef: ack=%b err=%b required 1 0", r_ack, r_err);
        end
        do_cmd(OP_UPDATE, K_CAFE, '0, 7'd1, 32'hfefefefe);
        checks++; if (r_ack !== 1'b1 || r_err !== 1'b0 || r_single !== 1'b1 || r_val !== 32'hfefefefe) begin
            failures++; $display("FAIL update_cafe: err=%b sh=%b val=%h required 0 1 fefefefe", r_err, r_single, r_val);
        end
        do_cmd(OP_SEARCH, K_CAFE, '0, 7'd0, 32'h0);
        checks++; if (r_single !== 1'b1 || r_val !== 32'hfefefefe || r_pri !== 7'd1) begin
            failures++; $display("FAIL search_updated: sh=%b pri=%0d val=%h required 1 1 fefefefe", r_single, r_pri, r_val);
        end
        do_cmd(OP_SEARCH, K_BEEF, '0, 7'd0, 32'h0);
        checks++; if (r_single !== 1'b1 || r_val !== 32'ha5a5a5a5) begin
            failures++; $display("FAIL search_beef: sh=%b val=%h required 1 a5a5a5a5", r_single, r_val);
        end
        do_cmd(OP_READ, K_BEEF, '0, 7'd0, 32'h0);
        checks++; if (r_single !== 1'b1 || r_err !== 1'b0 || r_val !== 32'ha5a5a5a5 || r_key !== K_BEEF) begin
            failures++; $display("FAIL read_beef: sh=%b err=%b val=%h required 1 0 a5a5a5a5", r_single, r_err, r_val);
        end
        do_cmd(OP_WRITE, K_CAFE, '0, 7'd0, 32'h11111111);
        checks++; if (r_err !== 1'b1 || r_val !== 32'h0) begin
            failures++; $display("FAIL write_dup: err=%b val=%h required 1 00000000", r_err, r_val);
        end
    endtask

    task automatic test_erase();
        do_cmd(OP_ERASE, K_CAFE, '0, 7'd0, 32'h0);
        checks++; if (r_ack !== 1'b1 || r_single !== 1'b1 || r_err !== 1'b0) begin
            failures++; $display("FAIL erase_cafe: ack=%b sh=%b err=%b required 1 1 0", r_ack, r_single, r_err);
        end
        do_cmd(OP_SEARCH, K_CAFE, '0, 7'd0, 32'h0);
        checks++; if (r_single !== 1'b0 || r_multi !== 1'b0 || r_err !== 1'b0 || r_val !== 32'h0) begin
            failures++; $display("FAIL search_erased: sh=%b mh=%b err=%b val=%h required 0 0 0 00000000",
                                 r_single, r_multi, r_err, r_val);
        end
        do_cmd(OP_SEARCH, K_BEEF, '0, 7'd0, 32'h0);
        checks++; if (r_single !== 1'b1 || r_val !== 32'ha5a5a5a5) begin
            failures++; $display("FAIL beef_survives: sh=%b val=%h required 1 a5a5a5a5", r_single, r_val);
        end
        do_cmd(OP_ERASE, K_CAFE, '0, 7'd0, 32'h0);
        checks++; if (r_err !== 1'b1 || r_single !== 1'b0) begin
            failures++; $display("FAIL erase_miss: err=%b sh=%b required 1 0", r_err, r_single);
        end
        do_cmd(OP_READ, K_CAFE, '0, 7'd0, 32'h0);
        checks++; if (r_err !== 1'b1 || r_val !== 32'h0 || r_key !== 128'h0) begin
            failures++; $display("FAIL read_miss: err=%b val=%h required 1 00000000", r_err, r_val);
        end
    endtask

    task automatic test_multi_hit();
        do_cmd(OP_WRITE, 128'h100, '0, 7'd5, 32'h55);
        do_cmd(OP_WRITE, 128'h200, '0, 7'd2, 32'h22);
        do_cmd(OP_WRITE, 128'h300, '0, 7'd2, 32'h33);
        checks++; if (r_err !== 1'b0) begin
            failures++; $display("FAIL write_multi: err=%b required 0", r_err);
        end
        // Bits 11:8 don't-care: all three entries match, pri 2 tie -> lower index (0x200)
        do_cmd(OP_SEARCH, 128'h0, 128'hF00, 7'd0, 32'h0);
        checks++; if (r_multi !== 1'b1 || r_single !== 1'b0 || r_err !== 1'b0 ||
                      r_pri !== 7'd2 || r_val !== 32'h22 || r_key !== 128'h200) begin
            failures++; $display("FAIL multi_hit: mh=%b sh=%b pri=%0d val=%h key=%h required 1 0 2 00000022 200",
                                 r_multi, r_single, r_pri, r_val, r_key);
        end
        do_cmd(OP_SEARCH, 128'h100, '0, 7'd0, 32'h0);
        checks++; if (r_single !== 1'b1 || r_multi !== 1'b0 || r_pri !== 7'd5 || r_val !== 32'h55) begin
            failures++; $display("FAIL single_masked: sh=%b mh=%b pri=%0d val=%h required 1 0 5 00000055",
                                 r_single, r_multi, r_pri, r_val);
        end
    endtask

    task automatic test_bad_opcode();
        do_cmd(OP_WRITE | OP_UPDATE, 128'h4000, '0, 7'd0, 32'h44);
        checks++; if (r_ack !== 1'b1 || r_err !== 1'b1 || r_single !== 1'b0 || r_val !== 32'h0) begin
            failures++; $display("FAIL two_opbits: ack=%b err=%b sh=%b val=%h required 1 1 0 00000000",
                                 r_ack, r_err, r_single, r_val);
        end
        do_cmd(5'b00000, 128'h4000, '0, 7'd0, 32'h44);
        checks++; if (r_ack !== 1'b1 || r_err !== 1'b1) begin
            failures++; $display("FAIL zero_opbits: ack=%b err=%b required 1 1", r_ack, r_err);
        end
        do_cmd(OP_READ, 128'h4000, '0, 7'd0, 32'h0);
        checks++; if (r_err !== 1'b1) begin
            failures++; $display("FAIL bad_op_no_change: err=%b required 1", r_err);
        end
    endtask

    task automatic test_ent_full();
        pulse_init();
        checks++; if (O_READY !== 1'b0) begin
            failures++; $display("FAIL init_drops_ready: got %b required 0", O_READY);
        end
        wait_ready();
        checks++; if (O_READY !== 1'b1 || O_ENT_FULL !== 1'b0) begin
            failures++; $display("FAIL init_done: ready=%b efull=%b required 1 0", O_READY, O_ENT_FULL);
        end
        for (int k = 0; k < 16; k++) begin
            do_cmd(OP_WRITE, 128'h1000 + 128'(k), '0, 7'(k), 32'h1000 + 32'(k));
            if (k == 14) begin
                checks++; if (O_ENT_FULL !== 1'b0) begin
                    failures++; $display("FAIL ent_full_15: got %b required 0", O_ENT_FULL);
                end
            end
        end
        checks++; if (r_err !== 1'b0 || O_ENT_FULL !== 1'b1) begin
            failures++; $display("FAIL ent_full_16: err=%b efull=%b required 0 1", r_err, O_ENT_FULL);
        end
        do_cmd(OP_WRITE, 128'h1fff, '0, 7'd0, 32'h1fff);
        checks++; if (r_ack !== 1'b1 || r_err !== 1'b1) begin
            failures++; $display("FAIL write_17: ack=%b err=%b required 1 1", r_ack, r_err);
        end
    endtask

    task automatic test_back_to_back();
        int ack_cnt;
        int first_c;
        int last_c;
        pulse_init();
        for (int k = 0; k < 9; k++) begin
            {I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ, I_CMD_SEARCH, I_CMD_UPDATE} = OP_WRITE;
            I_KEY_DAT = 128'h2000 + 128'(k); I_EKEY_MSK = '0;
            I_KEY_PRI = 7'd1; I_KEY_VALUE = 32'h100 + 32'(k);
            I_CMD_VALID = 1'b1;
            @(posedge I_CLK); #1;
        end
        I_CMD_VALID = 1'b0;
        {I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ, I_CMD_SEARCH, I_CMD_UPDATE} = 5'b0;
        checks++; if (O_CMD_FULL !== 1'b1 || O_WAIT !== 1'b1 || O_READY !== 1'b0) begin
            failures++; $display("FAIL fifo_full_in_init: full=%b wait=%b ready=%b required 1 1 0",
                                 O_CMD_FULL, O_WAIT, O_READY);
        end
        ack_cnt = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge I_CLK); #1;
            if (O_ACK === 1'b1) begin
                $display("txn drain ack=%0d cycle=%0d err=%0b val=%h", ack_cnt, c, O_ENT_ERR, O_KEY_VALUE);
                checks++; if (O_ENT_ERR !== 1'b0 || O_KEY_VALUE !== 32'h100 + 32'(ack_cnt)) begin
                    failures++; $display("FAIL drain_order: err=%b val=%h required 0 %h",
                                         O_ENT_ERR, O_KEY_VALUE, 32'h100 + 32'(ack_cnt));
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                ack_cnt++;
            end
        end
        checks++; if (ack_cnt != 8 || (last_c - first_c) != 7 || O_CMD_EMPTY !== 1'b1) begin
            failures++; $display("FAIL drain_count: acks=%0d span=%0d empty=%b required 8 7 1",
                                 ack_cnt, last_c - first_c, O_CMD_EMPTY);
        end
        do_cmd(OP_READ, 128'h2008, '0, 7'd0, 32'h0);
        checks++; if (r_err !== 1'b1) begin
            failures++; $display("FAIL ninth_dropped: err=%b required 1", r_err);
        end
        do_cmd(OP_READ, 128'h2007, '0, 7'd0, 32'h0);
        checks++; if (r_err !== 1'b0 || r_single !== 1'b1 || r_val !== 32'h107) begin
            failures++; $display("FAIL eighth_kept: err=%b sh=%b val=%h required 0 1 00000107", r_err, r_single, r_val);
        end
    endtask

    task automatic test_reset_midcmd();
        logic ack_seen;
        ack_seen = 1'b0;
        {I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ, I_CMD_SEARCH, I_CMD_UPDATE} = OP_WRITE;
        I_KEY_DAT = 128'h3000; I_EKEY_MSK = '0; I_KEY_PRI = 7'd0; I_KEY_VALUE = 32'h3000;
        I_CMD_VALID = 1'b1;
        @(posedge I_CLK); #1;
        I_CMD_VALID = 1'b0;
        {I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ, I_CMD_SEARCH, I_CMD_UPDATE} = 5'b0;
        I_RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge I_CLK); #1;
            if (O_ACK === 1'b1) ack_seen = 1'b1;
        end
        checks++; if (O_CMD_EMPTY !== 1'b1 || O_READY !== 1'b0 || O_ENT_FULL !== 1'b0) begin
            failures++; $display("FAIL midcmd_reset_state: empty=%b ready=%b efull=%b required 1 0 0",
                                 O_CMD_EMPTY, O_READY, O_ENT_FULL);
        end
        I_RST = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge I_CLK); #1;
            if (O_ACK === 1'b1) ack_seen = 1'b1;
            if (O_READY === 1'b1) break;
        end
        checks++; if (ack_seen !== 1'b0 || O_READY !== 1'b1) begin
            failures++; $display("FAIL midcmd_no_ack: ack_seen=%b ready=%b required 0 1", ack_seen, O_READY);
        end
        do_cmd(OP_READ, 128'h3000, '0, 7'd0, 32'h0);
        checks++; if (r_ack !== 1'b1 || r_err !== 1'b1) begin
            failures++; $display("FAIL midcmd_discarded: ack=%b err=%b required 1 1", r_ack, r_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_search();
        test_update();
        test_erase();
        test_multi_hit();
        test_bad_opcode();
        test_ent_full();
        test_back_to_back();
        test_reset_midcmd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axonerve_kvs_kernel.md
AXONERVE_KVS_KERNEL -- requirements
Module: axonerve_kvs_kernel

Interface
REQ-001 Parameter ENTRIES, default 16, number of key/value entries.
REQ-002 Parameter FIFO_DEPTH, default 8, command FIFO depth.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; I_CLK in 1 is the rising-edge clock and all logic is clocked by it.
REQ-004 I_RST in 1: synchronous, active-high reset.
REQ-005 I_CMD_INIT in 1: table-clear request.
REQ-006 I_CMD_VALID in 1: command push strobe.
REQ-007 I_CMD_ERASE in 1: erase opcode bit.
REQ-008 I_CMD_WRITE in 1: write opcode bit.
REQ-009 I_CMD_READ in 1: read opcode bit.
REQ-010 I_CMD_SEARCH in 1: search opcode bit.
REQ-011 I_CMD_UPDATE in 1: update opcode bit.
REQ-012 I_KEY_DAT in 128: key.
REQ-013 I_EKEY_MSK in 128: key mask; bit=1 means don't-care.
REQ-014 I_KEY_PRI in 7: entry priority; 0 is highest.
REQ-015 I_KEY_VALUE in 32: value.
REQ-016 O_VERSION out 32: constant 32'h0001_0000.
REQ-017 O_READY out 1: table initialised, executing commands.
REQ-018 O_WAIT out 1: equals !O_READY | O_CMD_FULL.
REQ-019 O_ACK out 1: one-cycle pulse per completed command.
REQ-020 O_ENT_ERR out 1: command failed; qualified by O_ACK.
REQ-021 O_SINGLE_HIT out 1: exactly one matching entry.
REQ-022 O_MULTIL_HIT out 1: two or more matching entries.
REQ-023 O_KEY_DAT out 128: result key.
REQ-024 O_EKEY_MSK out 128: result mask.
REQ-025 O_KEY_PRI out 7: result priority.
REQ-026 O_KEY_VALUE out 32: result value.
REQ-027 O_CMD_EMPTY out 1: command FIFO empty.
REQ-028 O_CMD_FULL out 1: command FIFO full.
REQ-029 O_ENT_FULL out 1: all entries valid.

Function
REQ-030 Each entry SHALL hold valid, key[127:0], mask[127:0], pri[6:0] and value[31:0].
REQ-031 Push: I_CMD_VALID=1 with O_CMD_FULL=0 and I_CMD_INIT=0 SHALL write {opcode, key, mask, pri, value} into the FIFO; a push while full SHALL be dropped.
REQ-032 Execution: when O_READY=1 and the FIFO is non-empty, the head SHALL be popped and executed, one command per cycle; with an empty FIFO, O_ACK and results are registered on the second rising edge after the sampling edge, with sustained throughput of one command per cycle.
REQ-033 Exact match SHALL mean the entry is valid with key and mask equal to the command's.
REQ-034 Search match SHALL mean the entry is valid and ((entry.key ^ cmd.key) & ~(entry.mask | cmd.mask)) == 0.
REQ-035 WRITE: an exact match exists -> ENT_ERR=1, no change; else store into the lowest-index free entry; no free entry -> ENT_ERR=1.
REQ-036 UPDATE: replace value and pri of the exact-match entry; no match -> ENT_ERR=1.
REQ-037 ERASE: invalidate the exact-match entry; no match -> ENT_ERR=1.
REQ-038 READ: return the exact-match entry; no match -> ENT_ERR=1.
REQ-039 SEARCH: count search matches; 1 -> SINGLE_HIT; >=2 -> MULTIL_HIT; report the winner (lowest pri, tie broken by lowest index); 0 matches -> no hit flag and ENT_ERR=0.
REQ-040 Result fields SHALL carry the affected or winning entry (WRITE echoes the written data); on miss or error the fields SHALL be 0.
REQ-041 SINGLE_HIT SHALL be 1 on a successful READ, UPDATE or ERASE.
REQ-042 Zero or multiple opcode bits set: the command SHALL be accepted, perform no table change, and ACK with ENT_ERR=1.
REQ-043 Init: sampled I_CMD_INIT=1 SHALL flush the FIFO and drop O_READY, then invalidate one entry per cycle for ENTRIES cycles before setting O_READY=1; pushes during init are queued; INIT beats a same-cycle VALID.

Reset
REQ-044 I_RST=1 SHALL override everything: all outputs 0 except O_CMD_EMPTY=1, O_WAIT=1 and O_VERSION; the FIFO is emptied; then the init sequence runs, with O_READY=1 ENTRIES cycles after reset release.
REQ-045 Asserting reset mid-command SHALL discard in-flight and queued commands without producing an ACK.

Verification
REQ-046 Write key 0xabadcafe x4, mask 0, value 0x34343434 -> ACK, ENT_ERR=0; search the same key -> SINGLE_HIT, value 0x34343434.
REQ-047 Write 0xdeadbeef x4 / 0xa5a5a5a5; update 0xabadcafe to 0xfefefefe -> searches return 0xfefefefe and 0xa5a5a5a5 respectively.
REQ-048 Erase 0xabadcafe -> ACK, SINGLE_HIT; a following search of it -> no hit, value 0; 0xdeadbeef still hits.
REQ-049 Two entries both matching a masked search, pri 5 and pri 2 -> MULTIL_HIT, pri 2 entry reported.
REQ-050 16 distinct writes -> O_ENT_FULL=1; 17th write -> ENT_ERR=1; 9 pushes during init -> O_CMD_FULL, 9th dropped, 8 ACKs after O_READY.
